// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// gshare_predictor
//
// Gshare branch predictor with a direct-mapped branch target buffer (BTB).
// The fetch stage looks up the BTB and a pattern history table (PHT) of
// saturating counters. The PHT is indexed by the PC index XOR the global
// history register (GHR). Resolved branches and jumps come back from the
// EX/MEM stage. They train the PHT, allocate BTB entries on a miss, and
// repair the GHR and the fetch PC on a mispredict.
//
// Parameters
//   INDEX_WIDTH  log2 of BTB/PHT entries. PC[INDEX_WIDTH+1:2] is the index
//                and PC[31:INDEX_WIDTH+2] is the tag.
//   GHR_WIDTH    global history length, 1..INDEX_WIDTH
//   CNT_WIDTH    PHT counter width, 2..4
//
// Configuration macro
//   GSHARE_SPEC_HIST_EN  When defined, the GHR is updated speculatively at
//                        fetch. The GHR shifts in the prediction on each
//                        fired BTB hit, and mispredict recovery takes
//                        priority. When undefined, the GHR is updated only
//                        at commit and IF_fire_i is ignored.
//
// Ports
//   clk_i                 clock; all state updates on the rising edge
//   rst_i                 asynchronous reset, active low
//   IF_fire_i             fetch advances this cycle
//   IF_PC_tag_i           fetch PC tag
//   IF_btb_rd_index_i     fetch PC index
//   EXMEM_btb_wr_index_i  committing PC index
//   EXMEM_btb_wr_tag_i    committing PC tag
//   EXMEM_btb_wr_target_i resolved target
//   EXMEM_btb_hit_i       BTB hit seen at fetch for this instruction
//   EXMEM_br_decision_i   actual outcome (1 = taken)
//   EXMEM_is_jmp_i        committing instruction is a branch/jump
//   EXMEM_prediction_i    prediction made at fetch
//   EXMEM_ghr_i           GHR snapshot carried from fetch
//   IF_btb_hit_o          BTB hit for the fetch PC
//   IF_prediction_o       predicted taken
//   IF_flush_o            mispredict flush
//   IF_PCnext_sel_o       00 seq, 01 fix to not-taken, 10 predicted target,
//                         11 fix to resolved target
//   IF_btb_rd_target_o    BTB target for the fetch PC
//   IF_ghr_o              GHR used for this fetch
// ---------------------------------------------------------------------------
module gshare_predictor #(
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned GHR_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH   = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        IF_fire_i,
  input  logic [31-INDEX_WIDTH-2:0]   IF_PC_tag_i,
  input  logic [INDEX_WIDTH-1:0]      IF_btb_rd_index_i,
  input  logic [INDEX_WIDTH-1:0]      EXMEM_btb_wr_index_i,
  input  logic [31-INDEX_WIDTH-2:0]   EXMEM_btb_wr_tag_i,
  input  logic [31:0]                 EXMEM_btb_wr_target_i,
  input  logic                        EXMEM_btb_hit_i,
  input  logic                        EXMEM_br_decision_i,
  input  logic                        EXMEM_is_jmp_i,
  input  logic                        EXMEM_prediction_i,
  input  logic [GHR_WIDTH-1:0]        EXMEM_ghr_i,
  output logic                        IF_btb_hit_o,
  output logic                        IF_prediction_o,
  output logic                        IF_flush_o,
  output logic [1:0]                  IF_PCnext_sel_o,
  output logic [31:0]                 IF_btb_rd_target_o,
  output logic [GHR_WIDTH-1:0]        IF_ghr_o
);

  localparam int unsigned TAG_WIDTH = 32 - INDEX_WIDTH - 2;
  localparam int unsigned ENTRIES   = 1 << INDEX_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  // Weakly not-taken: 0111..1 (MSB clear, all lower bits set).
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_FIX_NT = 2'b01,
    SEL_PRED   = 2'b10,
    SEL_FIX_T  = 2'b11
  } pcsel_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ENTRIES-1:0]   r_btb_valid;
  logic [TAG_WIDTH-1:0] r_btb_tag    [ENTRIES];
  logic [31:0]          r_btb_target [ENTRIES];
  logic [CNT_WIDTH-1:0] r_pht        [ENTRIES];
  logic [GHR_WIDTH-1:0] r_ghr;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] w_pht_rd_idx;
  logic [INDEX_WIDTH-1:0] w_pht_wr_idx;
  logic [CNT_WIDTH-1:0]   w_rd_cnt;
  logic [CNT_WIDTH-1:0]   w_wr_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   w_btb_wr;
  logic                   w_mispredict;
  logic [GHR_WIDTH-1:0]   w_ghr_recover;
  logic [GHR_WIDTH-1:0]   w_ghr_next;
  pcsel_e                 w_sel;

  // Shift a history vector left by one and insert b at bit 0. The cast
  // keeps the low GHR_WIDTH bits, so GHR_WIDTH == 1 reduces to just b.
  function automatic logic [GHR_WIDTH-1:0] f_hist_shift(
    input logic [GHR_WIDTH-1:0] h,
    input logic                 b
  );
    f_hist_shift = GHR_WIDTH'({h, b});
  endfunction

  // -------------------------------------------------------------------------
  // Fetch-side lookup. Reads are combinational from the current arrays, so
  // a same-cycle commit to the same entry is seen only on the next cycle.
  // -------------------------------------------------------------------------
  assign w_pht_rd_idx       = IF_btb_rd_index_i ^ INDEX_WIDTH'(r_ghr);
  assign w_rd_cnt           = r_pht[w_pht_rd_idx];
  assign IF_btb_hit_o       = r_btb_valid[IF_btb_rd_index_i] &&
                              (r_btb_tag[IF_btb_rd_index_i] == IF_PC_tag_i);
  assign IF_btb_rd_target_o = r_btb_target[IF_btb_rd_index_i];
  assign IF_prediction_o    = IF_btb_hit_o & w_rd_cnt[CNT_WIDTH-1];
  assign IF_ghr_o           = r_ghr;

  // -------------------------------------------------------------------------
  // Commit-side resolution. The mispredict is masked while reset is held,
  // so the redirect outputs read as idle during reset.
  // -------------------------------------------------------------------------
  assign w_mispredict = rst_i & EXMEM_is_jmp_i &
                        (EXMEM_prediction_i != EXMEM_br_decision_i);

  always_comb begin
    w_sel      = SEL_SEQ;
    IF_flush_o = 1'b0;
    if (w_mispredict) begin
      IF_flush_o = 1'b1;
      w_sel      = EXMEM_br_decision_i ? SEL_FIX_T : SEL_FIX_NT;
    end else if (IF_prediction_o) begin
      w_sel = SEL_PRED;
    end
  end

  assign IF_PCnext_sel_o = w_sel;

  // -------------------------------------------------------------------------
  // PHT training
  // -------------------------------------------------------------------------
  assign w_pht_wr_idx = EXMEM_btb_wr_index_i ^ INDEX_WIDTH'(EXMEM_ghr_i);
  assign w_wr_cnt     = r_pht[w_pht_wr_idx];

  always_comb begin
    w_cnt_next = w_wr_cnt;
    if (EXMEM_br_decision_i) begin
      if (w_wr_cnt != CNT_MAX) begin
        w_cnt_next = w_wr_cnt + CNT_WIDTH'(1);
      end
    end else if (w_wr_cnt != '0) begin
      w_cnt_next = w_wr_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_pht[i] <= CNT_INIT;
      end
    end else if (EXMEM_is_jmp_i) begin
      r_pht[w_pht_wr_idx] <= w_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // BTB allocation on a branch that missed at fetch. Only the valid bits
  // need reset; tag and target are don't-care while invalid.
  // -------------------------------------------------------------------------
  assign w_btb_wr = EXMEM_is_jmp_i & ~EXMEM_btb_hit_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_btb_valid <= '0;
    end else if (w_btb_wr) begin
      r_btb_valid[EXMEM_btb_wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && w_btb_wr) begin
      r_btb_tag[EXMEM_btb_wr_index_i]    <= EXMEM_btb_wr_tag_i;
      r_btb_target[EXMEM_btb_wr_index_i] <= EXMEM_btb_wr_target_i;
    end
  end

  // -------------------------------------------------------------------------
  // Global history
  // -------------------------------------------------------------------------
  assign w_ghr_recover = f_hist_shift(EXMEM_ghr_i, EXMEM_br_decision_i);

`ifdef GSHARE_SPEC_HIST_EN
  always_comb begin
    w_ghr_next = r_ghr;
    if (w_mispredict) begin
      w_ghr_next = w_ghr_recover;
    end else if (IF_fire_i && IF_btb_hit_o) begin
      w_ghr_next = f_hist_shift(r_ghr, IF_prediction_o);
    end
  end
`else
  logic w_unused_fire;
  assign w_unused_fire = IF_fire_i;

  always_comb begin
    w_ghr_next = r_ghr;
    if (EXMEM_is_jmp_i) begin
      w_ghr_next = w_mispredict ? w_ghr_recover
                                : f_hist_shift(r_ghr, EXMEM_br_decision_i);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ghr <= '0;
    end else begin
      r_ghr <= w_ghr_next;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  localparam int IW = 4;
  localparam int GW = 4;
  localparam int CW = 2;
  localparam int TW = 32 - IW - 2;
  localparam int NE = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fire;
  logic [TW-1:0] rtag;
  logic [IW-1:0] ridx;
  logic [IW-1:0] widx;
  logic [TW-1:0] wtag;
  logic [31:0]   wtgt;
  logic          exhit, dec, jmp, epred;
  logic [GW-1:0] eghr;
  logic          o_hit, o_pred, o_flush;
  logic [1:0]    o_sel;
  logic [31:0]   o_tgt;
  logic [GW-1:0] o_ghr;

  int total = 0;
  int bad   = 0;

  gshare_predictor #(.INDEX_WIDTH(IW), .GHR_WIDTH(GW), .CNT_WIDTH(CW)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_n),
    .IF_fire_i             (fire),
    .IF_PC_tag_i           (rtag),
    .IF_btb_rd_index_i     (ridx),
    .EXMEM_btb_wr_index_i  (widx),
    .EXMEM_btb_wr_tag_i    (wtag),
    .EXMEM_btb_wr_target_i (wtgt),
    .EXMEM_btb_hit_i       (exhit),
    .EXMEM_br_decision_i   (dec),
    .EXMEM_is_jmp_i        (jmp),
    .EXMEM_prediction_i    (epred),
    .EXMEM_ghr_i           (eghr),
    .IF_btb_hit_o          (o_hit),
    .IF_prediction_o       (o_pred),
    .IF_flush_o            (o_flush),
    .IF_PCnext_sel_o       (o_sel),
    .IF_btb_rd_target_o    (o_tgt),
    .IF_ghr_o              (o_ghr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    fire = 0; rtag = '0; ridx = '0; widx = '0; wtag = '0; wtgt = '0;
    exhit = 0; dec = 0; jmp = 0; epred = 0; eghr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- table-driven directed vectors ----------------
  typedef struct {
    logic          fire;
    logic [IW-1:0] ridx;
    logic [TW-1:0] rtag;
    logic          jmp;
    logic [IW-1:0] widx;
    logic [TW-1:0] wtag;
    logic [31:0]   wtgt;
    logic          exhit, dec, pred;
    logic [GW-1:0] eghr;
    logic          e_hit, e_pred;
    logic [1:0]    e_sel;
    logic          e_flush;
    logic [31:0]   e_tgt;
    logic [GW-1:0] e_ghr;
  } vec_t;

  function automatic vec_t mk(
    input logic f, input int ri, input int rt, input logic j, input int wi,
    input int wt, input int wg, input logic xh, input logic d, input logic p,
    input int eg, input logic eh, input logic ep, input int es, input logic ef,
    input int et, input int egh);
    vec_t v;
    v.fire = f; v.ridx = IW'(ri); v.rtag = TW'(rt); v.jmp = j; v.widx = IW'(wi);
    v.wtag = TW'(wt); v.wtgt = 32'(wg); v.exhit = xh; v.dec = d; v.pred = p;
    v.eghr = GW'(eg); v.e_hit = eh; v.e_pred = ep; v.e_sel = 2'(es);
    v.e_flush = ef; v.e_tgt = 32'(et); v.e_ghr = GW'(egh);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    fire = v.fire; ridx = v.ridx; rtag = v.rtag; jmp = v.jmp; widx = v.widx;
    wtag = v.wtag; wtgt = v.wtgt; exhit = v.exhit; dec = v.dec; epred = v.pred;
    eghr = v.eghr;
  endtask

  vec_t vt[13];

  // ---------------- behavioural reference model ----------------
  bit          m_val [NE];
  int unsigned m_tag [NE];
  int unsigned m_tgt [NE];
  int          m_pht [NE];
  int          m_ghr;

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_pht[i] = (1 << (CW - 1)) - 1;
    end
    m_ghr = 0;
  endtask

  initial begin
    logic [GW-1:0] spec_exp;
    idle();

    // Reset held with a mispredicting commit on the inputs: outputs stay idle.
    rst_n = 1'b0;
    ridx = 3; rtag = 26'h1234; jmp = 1; dec = 1; epred = 0;
    #1;
    chk("rst_hit", o_hit, 0);
    chk("rst_pred", o_pred, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_flush", o_flush, 0);
    chk("rst_ghr", o_ghr, 0);
    do_reset();

`ifndef GSHARE_SPEC_HIST_EN
    //        f ri  rt      j wi wt     wtgt   xh d p eg   | h p sel fl tgt    ghr
    vt[0]  = mk(0, 3, 'h77,   0, 0, 0,     0,     0, 0, 0, 0,  0, 0, 0, 0, 0,     0);
    vt[1]  = mk(0, 3, 'h1234, 1, 3, 'h1234,'h80,  0, 1, 0, 0,  0, 0, 3, 1, 0,     0);
    vt[2]  = mk(0, 3, 'h1234, 0, 0, 0,     0,     0, 0, 0, 0,  1, 0, 0, 0, 'h80,  1);
    vt[3]  = mk(0, 3, 'h1234, 1, 5, 'h55,  'h200, 0, 1, 1, 0,  1, 0, 0, 0, 'h80,  1);
    vt[4]  = mk(0, 3, 'h1234, 1, 5, 'h55,  'h200, 1, 1, 1, 0,  1, 0, 0, 0, 'h80,  3);
    vt[5]  = mk(0, 3, 'h1234, 1, 5, 'h55,  'h200, 1, 1, 1, 0,  1, 0, 0, 0, 'h80,  7);
    vt[6]  = mk(0, 3, 'h1234, 1, 5, 'h55,  'h200, 1, 0, 0, 0,  1, 0, 0, 0, 'h80,  15);
    vt[7]  = mk(0, 3, 'h1234, 1, 9, 'h99,  'h300, 1, 0, 1, 0,  1, 0, 1, 1, 'h80,  14);
    vt[8]  = mk(0, 5, 'h55,   0, 0, 0,     0,     0, 0, 0, 0,  1, 1, 2, 0, 'h200, 0);
    vt[9]  = mk(0, 5, 'h55,   1, 5, 'h55,  'h200, 1, 0, 0, 0,  1, 1, 2, 0, 'h200, 0);
    vt[10] = mk(0, 5, 'h55,   0, 0, 0,     0,     0, 0, 0, 0,  1, 0, 0, 0, 'h200, 0);
    vt[11] = mk(1, 5, 'h55,   1, 7, 'h77,  'h400, 1, 0, 1, 'hA,1, 0, 1, 1, 'h200, 0);
    vt[12] = mk(0, 3, 'h1234, 0, 0, 0,     0,     0, 0, 0, 0,  1, 0, 0, 0, 'h80,  4);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      chk($sformatf("vec%0d_hit", i), o_hit, vt[i].e_hit);
      chk($sformatf("vec%0d_pred", i), o_pred, vt[i].e_pred);
      chk($sformatf("vec%0d_sel", i), o_sel, vt[i].e_sel);
      chk($sformatf("vec%0d_flush", i), o_flush, vt[i].e_flush);
      chk($sformatf("vec%0d_ghr", i), o_ghr, vt[i].e_ghr);
      if (vt[i].e_hit) chk($sformatf("vec%0d_tgt", i), o_tgt, vt[i].e_tgt);
    end
`endif

    // ---------------- speculative history sequence ----------------
`ifdef GSHARE_SPEC_HIST_EN
    spec_exp = 4'b0111;
`else
    spec_exp = 4'b0011;
`endif
    do_reset();
    @(negedge clk);
    idle(); jmp = 1; widx = 3; wtag = 26'h1234; wtgt = 32'h80; dec = 1; epred = 0;
    #1;
    chk("seqA_sel", o_sel, 2'b11);
    chk("seqA_flush", o_flush, 1);
    @(negedge clk);
    idle(); jmp = 1; widx = 1; exhit = 1; dec = 1; epred = 0; eghr = 4'b0001;
    #1;
    chk("seqA1_ghr", o_ghr, 4'b0001);
    @(negedge clk);
    idle(); fire = 1; ridx = 3; rtag = 26'h1234;
    #1;
    chk("seqB_hit", o_hit, 1);
    chk("seqB_pred", o_pred, 1);
    chk("seqB_sel", o_sel, 2'b10);
    chk("seqB_ghr", o_ghr, 4'b0011);
    @(negedge clk);
    fire = 0;
    #1;
    chk("seqC_ghr", o_ghr, spec_exp);
    @(negedge clk);
    #1;
    chk("seqD_ghr", o_ghr, spec_exp);

    // ---------------- asynchronous reset mid-cycle ----------------
    @(negedge clk);
    idle(); ridx = 3; rtag = 26'h1234;
    jmp = 1; widx = 8; wtag = 26'h88; wtgt = 32'h123; dec = 1; epred = 0;
    #1;
    chk("ar_pre_hit", o_hit, 1);
    chk("ar_pre_sel", o_sel, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_hit", o_hit, 0);
    chk("ar_pred", o_pred, 0);
    chk("ar_sel", o_sel, 2'b00);
    chk("ar_flush", o_flush, 0);
    chk("ar_ghr", o_ghr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); ridx = 8; rtag = 26'h88;
    #1;
    chk("ar_nowrite_hit", o_hit, 0);
    jmp = 1; widx = 8; wtag = 26'h88; wtgt = 32'h123; dec = 1; epred = 0;
    @(negedge clk);
    idle(); ridx = 8; rtag = 26'h88;
    #1;
    chk("ar_post_hit", o_hit, 1);
    chk("ar_post_tgt", o_tgt, 32'h123);
    chk("ar_post_ghr", o_ghr, 4'b0001);

    // ---------------- randomized run against the model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      int  ri, rt, wi, eg, pi;
      bit  e_hit, e_pred, mis;
      int  e_sel;
      @(negedge clk);
      fire  = 1'($urandom % 2);
      ri    = int'($urandom % NE);
      rt    = int'($urandom % 3);
      ridx  = IW'(ri);
      rtag  = TW'(rt);
      jmp   = 1'($urandom % 2);
      wi    = int'($urandom % NE);
      widx  = IW'(wi);
      wtag  = TW'($urandom % 3);
      wtgt  = $urandom;
      exhit = ($urandom % 4) == 0;
      dec   = 1'($urandom % 2);
      epred = 1'($urandom % 2);
      eg    = int'($urandom % (1 << GW));
      eghr  = GW'(eg);
      #1;
      e_hit  = m_val[ri] && (m_tag[ri] == rt);
      e_pred = e_hit && (m_pht[ri ^ m_ghr] >= (1 << (CW - 1)));
      mis    = jmp && (epred != dec);
      e_sel  = mis ? (dec ? 3 : 1) : (e_pred ? 2 : 0);
      chk("rnd_hit", o_hit, e_hit);
      chk("rnd_pred", o_pred, e_pred);
      chk("rnd_sel", o_sel, e_sel);
      chk("rnd_flush", o_flush, mis);
      chk("rnd_ghr", o_ghr, m_ghr);
      if (e_hit) chk("rnd_tgt", o_tgt, m_tgt[ri]);
      // state after the coming rising edge
      if (jmp) begin
        pi = wi ^ eg;
        if (dec) m_pht[pi] = (m_pht[pi] == (1 << CW) - 1) ? m_pht[pi] : m_pht[pi] + 1;
        else     m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
        if (!exhit) begin
          m_val[wi] = 1; m_tag[wi] = int'(wtag); m_tgt[wi] = wtgt;
        end
      end
`ifdef GSHARE_SPEC_HIST_EN
      if (mis)                  m_ghr = ((eg * 2) + int'(dec)) % (1 << GW);
      else if (fire && e_hit)   m_ghr = ((m_ghr * 2) + int'(e_pred)) % (1 << GW);
`else
      if (mis)      m_ghr = ((eg * 2) + int'(dec)) % (1 << GW);
      else if (jmp) m_ghr = ((m_ghr * 2) + int'(dec)) % (1 << GW);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, 12, log2 of BTB/PHT entries; PC[INDEX_WIDTH+1:2] is the index, PC[31:INDEX_WIDTH+2] is the tag.
REQ-002 SHALL have parameter GHR_WIDTH, 8, global history bits, 1..INDEX_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, 2, PHT saturating-counter width, 2..4.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-low.
REQ-006 IF_fire_i  in  1  fetch advances this cycle.
REQ-007 IF_PC_tag_i / IF_btb_rd_index_i  in  32-INDEX_WIDTH-2 / INDEX_WIDTH  fetch-PC tag / index.
REQ-008 EXMEM_btb_wr_index_i / EXMEM_btb_wr_tag_i / EXMEM_btb_wr_target_i  in  INDEX_WIDTH / 32-INDEX_WIDTH-2 / 32  commit-stage PC index, PC tag, resolved target.
REQ-009 EXMEM_btb_hit_i, EXMEM_br_decision_i, EXMEM_is_jmp_i, EXMEM_prediction_i  in  1 each  piped-back hit, actual outcome, branch/jump flag, fetch-time prediction.
REQ-010 EXMEM_ghr_i  in  GHR_WIDTH  history snapshot carried from fetch with the branch.
REQ-011 IF_btb_hit_o, IF_prediction_o, IF_flush_o  out  1 each; IF_PCnext_sel_o  out  2; IF_btb_rd_target_o  out  32; IF_ghr_o  out  GHR_WIDTH  history used for this fetch (pipelined to commit).

Function
REQ-012 IF_btb_hit_o SHALL be 1 iff the indexed BTB entry is valid and its tag equals IF_PC_tag_i; combinational.
REQ-013 PHT read index SHALL be IF_btb_rd_index_i XOR zero-extended GHR; PHT update index SHALL be EXMEM_btb_wr_index_i XOR zero-extended EXMEM_ghr_i.
REQ-014 IF_prediction_o SHALL be IF_btb_hit_o AND MSB of the read counter.
REQ-015 mispredict = EXMEM_is_jmp_i AND (EXMEM_prediction_i != EXMEM_br_decision_i).
REQ-016 IF_PCnext_sel_o/IF_flush_o: mispredict with actual taken -> 2'b11/1; mispredict with actual not-taken -> 2'b01/1; otherwise IF_prediction_o ? 2'b10 : 2'b00, flush 0.
REQ-017 On EXMEM_is_jmp_i the indexed counter SHALL increment (outcome taken) or decrement (not taken), saturating at 2^CNT_WIDTH-1 and 0.
REQ-018 BTB SHALL write {valid=1, tag, target} when EXMEM_is_jmp_i AND NOT EXMEM_btb_hit_i.
REQ-019 Read and write to the same BTB/PHT entry in one cycle: read SHALL return the pre-write value; the write takes effect next cycle.
REQ-020 IF_ghr_o SHALL equal the current GHR register value.
REQ-021 On mispredict, GHR SHALL load {EXMEM_ghr_i[GHR_WIDTH-2:0], EXMEM_br_decision_i} (for GHR_WIDTH=1: the decision bit), regardless of IF_fire_i.

Reset
REQ-022 While rst_i=0: all BTB valid bits 0, every counter 2^(CNT_WIDTH-1)-1 (weakly not-taken), GHR 0; outputs therefore hit=0, prediction=0, PCnext_sel=2'b00, flush=0, IF_ghr_o=0.
REQ-023 Reset assertion mid-update SHALL override any pending write; first post-reset edge performs normal updates.

Configuration
REQ-024 Macro GSHARE_SPEC_HIST_EN defined: when IF_fire_i=1, no mispredict and IF_btb_hit_o=1, GHR SHALL shift left inserting IF_prediction_o; mispredict recovery (REQ-021) has priority.
REQ-025 Macro undefined: GHR SHALL update only at commit, shifting in EXMEM_br_decision_i on every EXMEM_is_jmp_i (REQ-021 value on mispredict); IF_fire_i ignored.

Verification (INDEX_WIDTH=4, GHR_WIDTH=4, CNT_WIDTH=2)
REQ-026 Reset then fetch index 3, any tag -> hit=0, prediction=0, sel=2'b00, flush=0, IF_ghr_o=4'b0000.
REQ-027 Commit index 3, tag 0x1234, target 0x80, miss, taken, predicted 0, ghr 0 -> same cycle sel=2'b11, flush=1; next cycle fetch index 3, tag 0x1234 -> hit=1, target 0x80, GHR=4'b0001.
REQ-028 Three taken commits on index 5 with ghr 0 from reset -> counter 01->10->11->11 (saturates); one not-taken -> 10, prediction still 1 at that index/history.
REQ-029 Predicted 1, actual 0, EXMEM_ghr_i=4'b1010, IF_fire_i=1 same cycle -> sel=2'b01, flush=1, GHR=4'b0100 next cycle (recovery beats speculative shift).
REQ-030 With GSHARE_SPEC_HIST_EN, GHR=4'b0011, fetch hit predicted taken, IF_fire_i=1 -> GHR=4'b0111; IF_fire_i=0 -> GHR unchanged; without macro -> GHR unchanged both cases.
REQ-031 Assert rst_i=0 asynchronously mid-cycle after entries written -> outputs return to REQ-022 values immediately, before next clock edge.
